// File: rtl/delta_demodulator_multichannel.sv
// Time-multiplexed delta demodulator: one up/down spike pair per slot updates that
// channel's saturating reconstruction, with per-channel step sizes held in a delta table.
module delta_demodulator_multichannel #(
  parameter int CHANNELS      = 16,
  parameter int WIDTH         = 16,
  parameter int DELTA_DEFAULT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        sync,
  input  logic                        pos_spike,
  input  logic                        neg_spike,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]            cfg_delta,
  output logic                        ready,
  output logic [WIDTH-1:0]            sample,
  output logic [$clog2(CHANNELS)-1:0] sample_ch,
  output logic                        valid,
  output logic                        conflict
);

  localparam int AW = $clog2(CHANNELS);
  localparam int EW = WIDTH + 2;
  localparam logic [AW-1:0] LAST_CH = AW'(CHANNELS - 1);

  // Two guard bits keep old +/- a full-range unsigned delta from wrapping before saturation.
  localparam logic signed [EW-1:0] SUM_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SUM_MIN = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     SMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     SMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t state, next_state;
  logic   clearing;

  logic [AW-1:0] sweep_addr;
  logic          sweep_last;
  logic [AW-1:0] chan_cnt;
  logic [AW-1:0] slot_ch;
  logic          accept;

  logic [WIDTH-1:0] recon_mem [CHANNELS];
  logic [WIDTH-1:0] delta_mem [CHANNELS];
  logic [WIDTH-1:0] recon_rd;
  logic [WIDTH-1:0] delta_rd;

  logic             recon_we;
  logic [AW-1:0]    recon_waddr;
  logic [WIDTH-1:0] recon_wdata;
  logic             delta_we;
  logic [AW-1:0]    delta_waddr;
  logic [WIDTH-1:0] delta_wdata;

  logic             s1_valid;
  logic [AW-1:0]    s1_ch;
  logic             s1_pos;
  logic             s1_neg;

  logic             s2_valid;
  logic [AW-1:0]    s2_ch;
  logic [WIDTH-1:0] s2_val;
  logic             s2_conflict;

  logic [WIDTH-1:0]     old_val;
  logic signed [EW-1:0] old_ext;
  logic signed [EW-1:0] delta_ext;
  logic signed [EW-1:0] sum_ext;
  logic [WIDTH-1:0]     new_val;

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == ST_CLEAR && sweep_last) next_state = ST_RUN;
  end

  always_comb begin
    ready    = (state == ST_RUN);
    clearing = (state == ST_CLEAR);
  end

  assign sweep_last = (sweep_addr == LAST_CH);

  always_ff @(posedge clk) begin
    if (rst)           sweep_addr <= '0;
    else if (clearing) sweep_addr <= sweep_last ? '0 : sweep_addr + 1'b1;
  end

  // ---------------------------------------------------------------- slot sequencing
  assign accept  = ready & en;
  assign slot_ch = sync ? '0 : chan_cnt;

  always_ff @(posedge clk) begin
    if (rst || clearing) chan_cnt <= '0;
    else if (accept)     chan_cnt <= (slot_ch == LAST_CH) ? '0 : slot_ch + 1'b1;
  end

  // ---------------------------------------------------------------- tables
  always_comb begin
    recon_we    = !rst && (clearing || s1_valid);
    recon_waddr = clearing ? sweep_addr : s1_ch;
    recon_wdata = clearing ? '0 : new_val;
    delta_we    = !rst && (clearing || (ready && cfg_we && int'(cfg_addr) < CHANNELS));
    delta_waddr = clearing ? sweep_addr : cfg_addr;
    delta_wdata = clearing ? WIDTH'(DELTA_DEFAULT) : cfg_delta;
  end

  // NOTE: the tables carry no reset so they map onto block RAM; the clear sweep
  // initialises them, and the registered read returns the word held before a same-edge write.
  always_ff @(posedge clk) begin
    if (recon_we) recon_mem[recon_waddr] <= recon_wdata;
    recon_rd <= recon_mem[slot_ch];
  end

  always_ff @(posedge clk) begin
    if (delta_we) delta_mem[delta_waddr] <= delta_wdata;
    delta_rd <= delta_mem[slot_ch];
  end

  // ---------------------------------------------------------------- stage 1: update
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_pos   <= 1'b0;
      s1_neg   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_ch    <= slot_ch;
      s1_pos   <= pos_spike;
      s1_neg   <= neg_spike;
    end
  end

  // The previous slot's result is still in flight when this read was issued.
  assign old_val = (s2_valid && s2_ch == s1_ch) ? s2_val : recon_rd;

  always_comb begin
    old_ext   = {{2{old_val[WIDTH-1]}}, old_val};
    delta_ext = {2'b00, delta_rd};
    unique case ({s1_pos, s1_neg})
      2'b10:   sum_ext = old_ext + delta_ext;
      2'b01:   sum_ext = old_ext - delta_ext;
      default: sum_ext = old_ext;
    endcase
    if (sum_ext > SUM_MAX)      new_val = SMP_MAX;
    else if (sum_ext < SUM_MIN) new_val = SMP_MIN;
    else                        new_val = sum_ext[WIDTH-1:0];
  end

  // ---------------------------------------------------------------- stage 2 and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_ch       <= '0;
      s2_val      <= '0;
      s2_conflict <= 1'b0;
    end else begin
      s2_valid    <= s1_valid;
      s2_ch       <= s1_ch;
      s2_val      <= new_val;
      s2_conflict <= s1_pos & s1_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      conflict  <= 1'b0;
      sample    <= '0;
      sample_ch <= '0;
    end else begin
      valid    <= s2_valid;
      conflict <= s2_valid & s2_conflict;
      if (s2_valid) begin
        sample    <= s2_val;
        sample_ch <= s2_ch;
      end
    end
  end

endmodule

// File: tb/tb_delta_demodulator_multichannel.sv
// Scoreboard bench: the driver queues hand-computed results per slot, and a monitor
// pops and compares each valid output, including its arrival cycle.
module tb_delta_demodulator_multichannel;

  localparam int CH = 16;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, sync = 1'b0, pos_spike = 1'b0, neg_spike = 1'b0;
  logic         cfg_we = 1'b0;
  logic [3:0]   cfg_addr = '0;
  logic [W-1:0] cfg_delta = '0;
  logic         ready, valid, conflict;
  logic [W-1:0] sample;
  logic [3:0]   sample_ch;

  delta_demodulator_multichannel #(
    .CHANNELS(CH), .WIDTH(W), .DELTA_DEFAULT(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .pos_spike(pos_spike), .neg_spike(neg_spike),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delta(cfg_delta),
    .ready(ready), .sample(sample), .sample_ch(sample_ch),
    .valid(valid), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int ch;
    int smp;
    int conf;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got ch %0d sample %0d, expected no output",
                 sample_ch, $signed(sample));
      end else begin
        mon_e = sb.pop_front();
        check("sample_ch", int'(sample_ch), mon_e.ch);
        check("sample", int'($signed(sample)), mon_e.smp);
        check("conflict", int'(conflict), mon_e.conf);
        check("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Drive one accepted slot; output is due on the third rising edge from now.
  task automatic slot(input logic s, input logic p, input logic n,
                      input int ech, input int esmp, input int econf);
    en = 1'b1; sync = s; pos_spike = p; neg_spike = n;
    sb.push_back('{ech, esmp, econf, cyc + 3});
    @(posedge clk); #1;
    en = 1'b0; sync = 1'b0; pos_spike = 1'b0; neg_spike = 1'b0;
  endtask

  task automatic cfg(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_delta = d[W-1:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Count negedges with ready low; optionally pulse en during the first few.
  task automatic wait_ready(input bit poke, output int n);
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      n++;
      en = poke && n < 8;
      pos_spike = poke && n < 8;
      @(negedge clk);
    end
    en = 1'b0; pos_spike = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state and clear sweep length
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(ready), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_sample_ch", int'(sample_ch), 0);
    check("rst_conflict", int'(conflict), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(1'b1, n);
    check("sweep_len", n, 16);

    // Two full frames of up-steps with the default delta of 1
    for (int pass = 1; pass <= 2; pass++)
      for (int c = 0; c < CH; c++)
        slot(1'b0, 1'b1, 1'b0, c, pass, 0);

    // Alternating ch0/ch1 back-to-back (2-cycle forwarding), delta 5, starting from 2
    cfg(0, 5);
    cfg(1, 5);
    for (int k = 1; k <= 4; k++) begin
      slot(1'b1, 1'b1, 1'b0, 0, 2 + 5 * k, 0);
      slot(1'b0, 1'b0, 1'b1, 1, 2 - 5 * k, 0);
    end
    // Same channel every cycle (1-cycle forwarding)
    for (int k = 1; k <= 3; k++)
      slot(1'b1, 1'b1, 1'b0, 0, 22 + 5 * k, 0);

    // ch2 to 7, then both spikes leave it unchanged and flag conflict
    cfg(2, 5);
    slot(1'b0, 1'b0, 1'b0, 1, -18, 0);
    slot(1'b0, 1'b1, 1'b0, 2, 7, 0);
    slot(1'b1, 1'b0, 1'b0, 0, 37, 0);
    slot(1'b0, 1'b0, 1'b0, 1, -18, 0);
    slot(1'b0, 1'b1, 1'b1, 2, 7, 1);
    // sync mid-frame restarts at channel 0
    slot(1'b1, 1'b0, 1'b0, 0, 37, 0);
    slot(1'b0, 1'b0, 1'b0, 1, -18, 0);

    // Delta write in the same cycle as a ch2 slot: old delta 5 applies, new 20 afterwards
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_delta = 8'd20;
    slot(1'b0, 1'b1, 1'b0, 2, 12, 0);
    cfg_we = 1'b0;
    slot(1'b1, 1'b0, 1'b0, 0, 37, 0);
    slot(1'b0, 1'b0, 1'b0, 1, -18, 0);
    slot(1'b0, 1'b1, 1'b0, 2, 32, 0);

    // Saturation on ch0 with delta 100, back-to-back
    cfg(0, 100);
    slot(1'b1, 1'b0, 1'b1, 0, -63, 0);
    slot(1'b1, 1'b0, 1'b1, 0, -128, 0);
    slot(1'b1, 1'b0, 1'b1, 0, -128, 0);
    slot(1'b1, 1'b1, 1'b0, 0, -28, 0);
    slot(1'b1, 1'b1, 1'b0, 0, 72, 0);
    slot(1'b1, 1'b1, 1'b0, 0, 127, 0);
    slot(1'b1, 1'b1, 1'b0, 0, 127, 0);
    repeat (4) @(posedge clk);
    #1;

    // Reset one cycle after an accepted slot: that slot must never appear
    en = 1'b1; sync = 1'b1; pos_spike = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; sync = 1'b0; pos_spike = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(1'b0, n);
    check("sweep_len_after_rst", n, 16);
    check("post_rst_sample", int'(sample), 0);
    check("post_rst_sample_ch", int'(sample_ch), 0);

    // All reconstructions cleared, and cfg'd deltas back to the default
    for (int c = 0; c < CH; c++)
      slot(1'b0, 1'b0, 1'b0, c, 0, 0);
    slot(1'b0, 1'b1, 1'b0, 0, 1, 0);
    slot(1'b0, 1'b0, 1'b0, 1, 0, 0);
    slot(1'b0, 1'b1, 1'b0, 2, 1, 0);

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
